// File: rtl/mc_datapath.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : mc_datapath                                                 |
// | Purpose  : Multi-cycle MIPS-subset core (add/sub/and/or/slt, lw, sw,   |
// |            beq, addi, j). One shared memory port with a req/ready      |
// |            handshake for fetch and data. Stalls on slow memory and     |
// |            halts on illegal opcode/funct.                              |
// | Ports    : clk, rst (async, active-low)                                |
// |            mem_req/mem_we/mem_addr/mem_wdata -> memory request         |
// |            mem_rdata/mem_ready <- memory response                      |
// |            pc_now (current PC), halted (1 while in HALT)               |
// | Options  : MC_DATAPATH_BNE_EN - adds bne (opcode 000101)               |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module mc_datapath #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_now,
  output logic              halted
);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
`ifdef MC_DATAPATH_BNE_EN
  localparam logic [5:0] C_OP_BNE   = 6'b000101;
`endif
  localparam logic [5:0] C_FN_ADD   = 6'b100000;
  localparam logic [5:0] C_FN_SUB   = 6'b100010;
  localparam logic [5:0] C_FN_AND   = 6'b100100;
  localparam logic [5:0] C_FN_OR    = 6'b100101;
  localparam logic [5:0] C_FN_SLT   = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q;
  logic        mem_req_q, mem_we_q, halted_q;
  logic [31:0] rf_q [32];

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd;
  logic [31:0] w_sext;
  logic        w_xfer;
  logic [31:0] w_alu_res;
  logic        w_fn_ok;
  logic        w_take;
  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;

  assign w_op   = ir_q[31:26];
  assign w_rs   = ir_q[25:21];
  assign w_rt   = ir_q[20:16];
  assign w_rd   = ir_q[15:11];
  assign w_fn   = ir_q[5:0];
  assign w_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  // A transfer completes only while a request is actually outstanding.
  assign w_xfer = mem_req_q & mem_ready;

`ifdef MC_DATAPATH_BNE_EN
  assign w_take = (w_op == C_OP_BNE) ? (a_q != b_q) : (a_q == b_q);
`else
  assign w_take = (a_q == b_q);
`endif

  always_comb begin
    w_alu_res = '0;
    w_fn_ok   = 1'b1;
    case (w_fn)
      C_FN_ADD: w_alu_res = a_q + b_q;
      C_FN_SUB: w_alu_res = a_q - b_q;
      C_FN_AND: w_alu_res = a_q & b_q;
      C_FN_OR:  w_alu_res = a_q | b_q;
      C_FN_SLT: w_alu_res = {31'd0, ($signed(a_q) < $signed(b_q))};
      default:  w_fn_ok   = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (w_xfer) state_d = S_DECODE;
      S_DECODE: begin
        case (w_op)
          C_OP_RTYPE:        state_d = S_EXEC;
          C_OP_LW, C_OP_SW:  state_d = S_MEMADR;
          C_OP_BEQ:          state_d = S_BRANCH;
`ifdef MC_DATAPATH_BNE_EN
          C_OP_BNE:          state_d = S_BRANCH;
`endif
          C_OP_ADDI:         state_d = S_ADDIEX;
          C_OP_J:            state_d = S_JUMP;
          default:           state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (w_op == C_OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (w_xfer) state_d = S_MEMWB;
      S_MEMWR:  if (w_xfer) state_d = S_FETCH;
      S_EXEC:   state_d = w_fn_ok ? S_ALUWB : S_HALT;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_HALT;
    endcase
  end

  // Register-file write port, active only in the three write-back states.
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = w_rt;
    w_rf_wdata = alu_q;
    case (state_q)
      S_MEMWB:  begin w_rf_we = 1'b1; w_rf_wdata = mdr_q; end
      S_ALUWB:  begin w_rf_we = 1'b1; w_rf_waddr = w_rd; end
      S_ADDIWB: w_rf_we = 1'b1;
      default:  ;
    endcase
  end

  // Register file carries no reset; r0 is never written and reads as zero.
  always_ff @(posedge clk) begin
    if (w_rf_we && (w_rf_waddr != 5'd0)) rf_q[w_rf_waddr] <= w_rf_wdata;
  end

  // Memory-port controls are registered from the next state so they are
  // valid from the first cycle of each request state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == S_FETCH) || (state_d == S_MEMRD) || (state_d == S_MEMWR);
      mem_we_q  <= (state_d == S_MEMWR);
      halted_q  <= (state_d == S_HALT);
      case (state_q)
        S_FETCH: if (w_xfer) begin
          ir_q <= mem_rdata;
          pc_q <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q   <= (w_rs == 5'd0) ? 32'd0 : rf_q[w_rs];
          b_q   <= (w_rt == 5'd0) ? 32'd0 : rf_q[w_rt];
          alu_q <= pc_q + {w_sext[29:0], 2'b00};
        end
        S_MEMADR, S_ADDIEX: alu_q <= a_q + w_sext;
        S_MEMRD:  if (w_xfer) mdr_q <= mem_rdata;
        S_EXEC:   alu_q <= w_alu_res;
        S_BRANCH: if (w_take) pc_q <= alu_q;
        S_JUMP:   pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
        default:  ;
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = (state_q == S_FETCH) ? pc_q[ADDR_W-1:0] : alu_q[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign pc_now    = pc_q[ADDR_W-1:0];
  assign halted    = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_mc_datapath                                              |
// | Purpose  : Directed self-checking bench for mc_datapath with a word    |
// |            memory model that answers after a configurable wait count.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_mc_datapath;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [31:0] HALT_I = 32'hFC00_0000;
  localparam logic [31:0] FILL   = 32'hDEAD_BEEF;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_now;

  mc_datapath #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_now(pc_now), .halted(halted)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          wait_cfg = 0;
  logic [31:0] mem [256];
  int          fetch_t [256];
  int          halt_t;
  int          nwrites;
  int          hold_err;
  logic [31:0] w_addr [8];
  logic [31:0] w_data [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responder: evaluates at the falling edge, the DUT samples at the rising edge.
  initial begin : g_mem
    int          wcnt;
    logic [31:0] t_addr, t_wd;
    logic        t_we;
    wcnt = 0; t_addr = '0; t_wd = '0; t_we = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && halted && halt_t < 0) halt_t = cyc;
      if (rst && mem_req) begin
        if (wcnt == 0) begin
          t_addr = mem_addr; t_we = mem_we; t_wd = mem_wdata;
        end else if (mem_addr !== t_addr || mem_we !== t_we || mem_wdata !== t_wd) begin
          hold_err++;
        end
        if (wcnt < wait_cfg) begin
          mem_ready = 1'b0;
          wcnt++;
        end else begin
          mem_ready = 1'b1;
          wcnt = 0;
          mem_rdata = mem[mem_addr[9:2]];
          if (mem_we) begin
            mem[mem_addr[9:2]] = mem_wdata;
            if (nwrites < 8) begin
              w_addr[nwrites] = mem_addr;
              w_data[nwrites] = mem_wdata;
            end
            nwrites++;
          end else if (mem_addr == pc_now) begin
            fetch_t[mem_addr[9:2]] = cyc;
          end
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic clear_mem();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = FILL;
  endtask

  task automatic run_prog(input int wcfg, input int budget);
    int n;
    wait_cfg = wcfg;
    for (int i = 0; i < 256; i++) fetch_t[i] = -1;
    halt_t = -1; nwrites = 0; hold_err = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    total++;
    if (halted !== 1'b1) begin
      bad++;
      $display("FAIL run_timeout halted=%0b required=1", halted);
    end
  endtask

  task automatic test_reset();
    int n;
    clear_mem();
    wait_cfg = 50;
    repeat (3) @(negedge clk);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%0b exp=0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", mem_we); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%0b exp=0", halted); end
    total++; if (pc_now !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_now); end
    rst = 1'b1;
    n = 0;
    while (mem_req !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%0b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", mem_addr); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL first_we got=%0b exp=0", mem_we); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL async_drop_req got=%0b exp=0", mem_req); end
    total++; if (pc_now !== 32'h0) begin bad++; $display("FAIL async_pc got=%h exp=0", pc_now); end
  endtask

  task automatic test_alu();
    clear_mem();
    mem[0]  = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    mem[1]  = enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
    mem[2]  = enc_r(5'd1, 5'd2, 5'd3, FN_ADD);
    mem[3]  = enc_r(5'd2, 5'd1, 5'd4, FN_SUB);
    mem[4]  = enc_r(5'd2, 5'd1, 5'd5, FN_SLT);
    mem[5]  = enc_r(5'd1, 5'd2, 5'd6, FN_AND);
    mem[6]  = enc_r(5'd1, 5'd2, 5'd7, FN_OR);
    mem[7]  = enc_r(5'd1, 5'd2, 5'd8, FN_SLT);
    mem[8]  = enc_i(OP_SW, 5'd0, 5'd3, 16'h0200);
    mem[9]  = enc_i(OP_SW, 5'd0, 5'd4, 16'h0204);
    mem[10] = enc_i(OP_SW, 5'd0, 5'd5, 16'h0208);
    mem[11] = enc_i(OP_SW, 5'd0, 5'd6, 16'h020C);
    mem[12] = enc_i(OP_SW, 5'd0, 5'd7, 16'h0210);
    mem[13] = enc_i(OP_SW, 5'd0, 5'd8, 16'h0214);
    mem[14] = HALT_I;
    run_prog(0, 300);
    total++; if (mem[128] !== 32'h2) begin bad++; $display("FAIL add got=%h exp=00000002", mem[128]); end
    total++; if (mem[129] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL sub got=%h exp=fffffff8", mem[129]); end
    total++; if (mem[130] !== 32'h1) begin bad++; $display("FAIL slt_true got=%h exp=00000001", mem[130]); end
    total++; if (mem[131] !== 32'h5) begin bad++; $display("FAIL and got=%h exp=00000005", mem[131]); end
    total++; if (mem[132] !== 32'hFFFF_FFFD) begin bad++; $display("FAIL or got=%h exp=fffffffd", mem[132]); end
    total++; if (mem[133] !== 32'h0) begin bad++; $display("FAIL slt_false got=%h exp=00000000", mem[133]); end
    total++; if (fetch_t[1] - fetch_t[0] !== 4) begin bad++; $display("FAIL addi_cycles got=%0d exp=4", fetch_t[1] - fetch_t[0]); end
    total++; if (fetch_t[5] - fetch_t[0] !== 20) begin bad++; $display("FAIL alu5_cycles got=%0d exp=20", fetch_t[5] - fetch_t[0]); end
    total++; if (fetch_t[9] - fetch_t[8] !== 4) begin bad++; $display("FAIL sw_cycles got=%0d exp=4", fetch_t[9] - fetch_t[8]); end
    total++; if (nwrites !== 6) begin bad++; $display("FAIL alu_nwrites got=%0d exp=6", nwrites); end
  endtask

  task automatic test_memory();
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    mem[1] = enc_j(OP_J, 26'd4);
    mem[4] = enc_i(OP_SW, 5'd0, 5'd1, 16'd8);
    mem[5] = enc_i(OP_LW, 5'd0, 5'd6, 16'd8);
    mem[6] = enc_i(OP_SW, 5'd0, 5'd6, 16'h0200);
    mem[7] = HALT_I;
    run_prog(3, 400);
    total++; if (nwrites !== 2) begin bad++; $display("FAIL mem_nwrites got=%0d exp=2", nwrites); end
    total++; if (w_addr[0] !== 32'h8) begin bad++; $display("FAIL sw_addr got=%h exp=00000008", w_addr[0]); end
    total++; if (w_data[0] !== 32'h5) begin bad++; $display("FAIL sw_wdata got=%h exp=00000005", w_data[0]); end
    total++; if (mem[128] !== 32'h5) begin bad++; $display("FAIL lw_value got=%h exp=00000005", mem[128]); end
    total++; if (hold_err !== 0) begin bad++; $display("FAIL req_hold got=%0d exp=0", hold_err); end
    total++; if (fetch_t[4] - fetch_t[1] !== 6) begin bad++; $display("FAIL j_wait_cycles got=%0d exp=6", fetch_t[4] - fetch_t[1]); end
    total++; if (fetch_t[5] - fetch_t[4] !== 10) begin bad++; $display("FAIL sw_wait_cycles got=%0d exp=10", fetch_t[5] - fetch_t[4]); end
    total++; if (fetch_t[6] - fetch_t[5] !== 11) begin bad++; $display("FAIL lw_wait_cycles got=%0d exp=11", fetch_t[6] - fetch_t[5]); end
  endtask

  task automatic test_control();
    clear_mem();
    mem[0]  = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd7);
    mem[1]  = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd9);
    mem[2]  = enc_i(OP_BEQ, 5'd1, 5'd1, 16'd2);
    mem[3]  = enc_i(OP_SW, 5'd0, 5'd1, 16'h0200);
    mem[4]  = enc_i(OP_SW, 5'd0, 5'd1, 16'h0204);
    mem[5]  = enc_i(OP_BEQ, 5'd1, 5'd2, 16'd5);
    mem[6]  = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd77);
    mem[7]  = enc_i(OP_SW, 5'd0, 5'd0, 16'h0208);
    mem[8]  = enc_j(OP_J, 26'h40);
    mem[9]  = HALT_I;
    mem[64] = enc_i(OP_SW, 5'd0, 5'd2, 16'h020C);
    mem[65] = HALT_I;
    run_prog(0, 300);
    total++; if (fetch_t[3] !== -1 || fetch_t[4] !== -1) begin bad++; $display("FAIL beq_skip got=%0d,%0d exp=-1,-1", fetch_t[3], fetch_t[4]); end
    total++; if (fetch_t[5] - fetch_t[2] !== 3) begin bad++; $display("FAIL beq_taken got=%0d exp=3", fetch_t[5] - fetch_t[2]); end
    total++; if (fetch_t[6] - fetch_t[5] !== 3) begin bad++; $display("FAIL beq_not_taken got=%0d exp=3", fetch_t[6] - fetch_t[5]); end
    total++; if (fetch_t[64] - fetch_t[8] !== 3) begin bad++; $display("FAIL j_target got=%0d exp=3", fetch_t[64] - fetch_t[8]); end
    total++; if (fetch_t[9] !== -1) begin bad++; $display("FAIL j_fallthrough got=%0d exp=-1", fetch_t[9]); end
    total++; if (mem[128] !== FILL || mem[129] !== FILL) begin bad++; $display("FAIL skipped_sw got=%h,%h exp=deadbeef", mem[128], mem[129]); end
    total++; if (mem[130] !== 32'h0) begin bad++; $display("FAIL r0_write got=%h exp=00000000", mem[130]); end
    total++; if (mem[131] !== 32'h9) begin bad++; $display("FAIL after_j got=%h exp=00000009", mem[131]); end
  endtask

  task automatic test_illegal();
    int nreq;
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
    mem[1] = HALT_I;
    run_prog(0, 100);
    total++; if (halt_t - fetch_t[1] !== 2) begin bad++; $display("FAIL op_halt_lat got=%0d exp=2", halt_t - fetch_t[1]); end
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) nreq++;
    end
    total++; if (nreq !== 0) begin bad++; $display("FAIL halt_no_req got=%0d exp=0", nreq); end
    rst = 1'b0;
    #1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_clears_halt got=%0b exp=0", halted); end
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
    mem[1] = enc_r(5'd1, 5'd1, 5'd3, 6'h00);
    mem[2] = enc_i(OP_SW, 5'd0, 5'd3, 16'h0200);
    mem[3] = HALT_I;
    run_prog(0, 100);
    total++; if (halt_t - fetch_t[1] !== 3) begin bad++; $display("FAIL fn_halt_lat got=%0d exp=3", halt_t - fetch_t[1]); end
    total++; if (fetch_t[2] !== -1) begin bad++; $display("FAIL fn_halt_fetch got=%0d exp=-1", fetch_t[2]); end
  endtask

  task automatic test_bne();
    clear_mem();
    mem[0] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd1);
    mem[1] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'd2);
    mem[2] = enc_i(OP_BNE, 5'd1, 5'd2, 16'd1);
    mem[3] = enc_i(OP_SW, 5'd0, 5'd1, 16'h0200);
    mem[4] = enc_i(OP_SW, 5'd0, 5'd2, 16'h0204);
    mem[5] = HALT_I;
    run_prog(0, 100);
    total++; if (fetch_t[3] !== -1) begin bad++; $display("FAIL bne_skip got=%0d exp=-1", fetch_t[3]); end
`ifdef MC_DATAPATH_BNE_EN
    total++; if (fetch_t[4] - fetch_t[2] !== 3) begin bad++; $display("FAIL bne_taken got=%0d exp=3", fetch_t[4] - fetch_t[2]); end
    total++; if (mem[129] !== 32'h2) begin bad++; $display("FAIL bne_target got=%h exp=00000002", mem[129]); end
`else
    total++; if (halt_t - fetch_t[2] !== 2) begin bad++; $display("FAIL bne_illegal got=%0d exp=2", halt_t - fetch_t[2]); end
    total++; if (mem[129] !== FILL) begin bad++; $display("FAIL bne_no_store got=%h exp=deadbeef", mem[129]); end
`endif
  endtask

  initial begin
    rst = 1'b0;
    halt_t = -1; nwrites = 0; hold_err = 0;
    for (int i = 0; i < 256; i++) fetch_t[i] = -1;
    test_reset();
    test_alu();
    test_memory();
    test_control();
    test_illegal();
    test_bne();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
